// File: rtl/delta_tb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : delta_tb_pkg
//  Description : Shared types and helpers for the delta trace buffer
//                controller: FSM state encoding and address-width derivation.
//  Revision    : 1.0 - initial release
// ============================================================================
package delta_tb_pkg;

    // Controller states; width fixed at 3 bits for five states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_POST  = 3'd2,
        ST_DONE  = 3'd3,
        ST_READ  = 3'd4
    } state_e;

    // Number of address bits needed to index a buffer of 'depth' entries.
    // Never returns less than 1 so a degenerate depth still yields a legal vector.
    function automatic int addr_w_f(input int depth);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/delta_tb_controller_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ptr_counter
//  Description : Modulo-2^ADDR_W pointer with synchronous load and increment.
//                Load has priority over increment; wrap is the natural
//                binary rollover because the buffer depth is a power of two.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ptr_counter #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] ptr_o
);

    logic [ADDR_W-1:0] ptr_q;

    // Pointer register: load wins over increment, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (load_i) begin
            ptr_q <= load_val_i;
        end else if (inc_i) begin
            ptr_q <= ptr_q + ADDR_W'(1);
        end
    end

    assign ptr_o = ptr_q;

endmodule
`default_nettype wire

// File: rtl/delta_tb_controller.sv
`default_nettype none
// ============================================================================
//  Module      : delta_tb_controller
//  Description : Trace buffer controller. Arms on start, writes compressor
//                output into a circular buffer, captures a programmable
//                number of post-trigger entries, then freezes the buffer and
//                reads it back oldest-first with ready/valid backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module delta_tb_controller
    import delta_tb_pkg::*;
#(
    parameter int  N          = 8,
    parameter int  TB_SIZE    = 64,
    parameter int  DATA_WIDTH = 32,
    localparam int ADDR_W     = addr_w_f(TB_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    input  logic              trigger_in,
    input  logic [ADDR_W-1:0] post_len_in,
    input  logic              comp_valid_in,
    input  logic              comp_flag_in,
    input  logic              comp_inc_in,
    output logic              tracing_out,
    output logic              tb_we_out,
    output logic              tb_flag_out,
    output logic [ADDR_W-1:0] tb_waddr_out,
    input  logic              read_start_in,
    input  logic              rd_ready_in,
    output logic              rd_en_out,
    output logic              rd_last_out,
    output logic [ADDR_W-1:0] rd_addr_out,
    output logic              done_out
);

    // Counters carry one extra bit so a full buffer (TB_SIZE) is representable.
    localparam int              CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(TB_SIZE);

    // N and DATA_WIDTH only travel with the package configuration; the
    // parameter sanity block below is the sole place they are referenced.
    if (TB_SIZE < 4 || (TB_SIZE & (TB_SIZE - 1)) != 0 || N < 1 || DATA_WIDTH < 1) begin : g_bad_params
    end

    state_e             state_q, state_d;
    logic               first_wr_q, first_wr_d;
    logic [CNT_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   post_cnt_q, post_cnt_d;
    logic [CNT_W-1:0]   rd_left_q, rd_left_d;
    logic [ADDR_W-1:0]  post_len_q, post_len_d;
    logic               tb_we_q, tb_we_d;
    logic               tb_flag_q, tb_flag_d;
    logic               tracing_q, tracing_d;
    logic               done_q, done_d;
    logic               rd_en_q, rd_en_d;
    logic               rd_last_q, rd_last_d;

    logic               w_wr_ev;
    logic               w_new_entry;
    logic               w_wr_load;
    logic               w_wr_inc;
    logic               w_rd_load;
    logic               w_rd_inc;
    logic [ADDR_W-1:0]  w_wptr;
    logic [ADDR_W-1:0]  w_rptr;
    logic [ADDR_W-1:0]  w_rd_start;

    // Write qualification: only while capturing. The very first write after
    // arming is forced to address 0; later ones advance only on comp_inc_in.
    assign w_wr_ev     = comp_valid_in && (state_q == ST_ARMED || state_q == ST_POST);
    assign w_new_entry = w_wr_ev && (!first_wr_q || comp_inc_in);
    assign w_wr_load   = w_wr_ev && !first_wr_q;
    assign w_wr_inc    = w_wr_ev && first_wr_q && comp_inc_in;

    // Oldest entry sits just past the newest once the buffer has wrapped.
    assign w_rd_start  = (fill_q == c_full_cnt) ? (w_wptr + ADDR_W'(1)) : '0;
    assign w_rd_load   = (state_q == ST_DONE) && read_start_in;
    assign w_rd_inc    = (state_q == ST_READ) && rd_en_q && rd_ready_in && !rd_last_q;

    tb_ptr_counter #(
        .ADDR_W     (ADDR_W)
    ) u_wr_ptr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (w_wr_load),
        .load_val_i ({ADDR_W{1'b0}}),
        .inc_i      (w_wr_inc),
        .ptr_o      (w_wptr)
    );

    tb_ptr_counter #(
        .ADDR_W     (ADDR_W)
    ) u_rd_ptr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (w_rd_load),
        .load_val_i (w_rd_start),
        .inc_i      (w_rd_inc),
        .ptr_o      (w_rptr)
    );

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d    = state_q;
        first_wr_d = first_wr_q;
        fill_d     = fill_q;
        post_cnt_d = post_cnt_q;
        rd_left_d  = rd_left_q;
        post_len_d = post_len_q;
        tb_we_d    = w_wr_ev;
        tb_flag_d  = w_wr_ev && comp_flag_in;
        rd_en_d    = rd_en_q;
        rd_last_d  = rd_last_q;

        if (w_wr_ev) begin
            first_wr_d = 1'b1;
        end
        if (w_new_entry && fill_q != c_full_cnt) begin
            fill_d = fill_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    state_d    = ST_ARMED;
                    fill_d     = '0;
                    post_cnt_d = '0;
                    first_wr_d = 1'b0;
                    post_len_d = post_len_in;
                end
            end
            ST_ARMED: begin
                if (trigger_in) begin
                    state_d = ST_POST;
                end
            end
            ST_POST: begin
                if (w_new_entry) begin
                    post_cnt_d = post_cnt_q + CNT_W'(1);
                end
                // Leave as soon as the count (including this cycle's write)
                // meets the target; a zero target leaves after one cycle.
                if (post_cnt_d >= {1'b0, post_len_q}) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (read_start_in) begin
                    state_d   = ST_READ;
                    rd_left_d = fill_q;
                    rd_en_d   = (fill_q != '0);
                    rd_last_d = (fill_q == CNT_W'(1));
                end else if (start_in) begin
                    state_d    = ST_ARMED;
                    fill_d     = '0;
                    post_cnt_d = '0;
                    first_wr_d = 1'b0;
                    post_len_d = post_len_in;
                end
            end
            ST_READ: begin
                if (!rd_en_q) begin
                    state_d = ST_IDLE;
                end else if (rd_ready_in) begin
                    if (rd_last_q) begin
                        state_d   = ST_IDLE;
                        rd_en_d   = 1'b0;
                        rd_last_d = 1'b0;
                    end else begin
                        rd_left_d = rd_left_q - CNT_W'(1);
                        rd_last_d = (rd_left_q == CNT_W'(2));
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                rd_en_d = 1'b0;
            end
        endcase

        tracing_d = (state_d == ST_ARMED) || (state_d == ST_POST);
        done_d    = (state_d == ST_DONE);
    end

    // State and output registers; reset aborts any capture or readout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            first_wr_q <= 1'b0;
            fill_q     <= '0;
            post_cnt_q <= '0;
            rd_left_q  <= '0;
            post_len_q <= '0;
            tb_we_q    <= 1'b0;
            tb_flag_q  <= 1'b0;
            tracing_q  <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            first_wr_q <= first_wr_d;
            fill_q     <= fill_d;
            post_cnt_q <= post_cnt_d;
            rd_left_q  <= rd_left_d;
            post_len_q <= post_len_d;
            tb_we_q    <= tb_we_d;
            tb_flag_q  <= tb_flag_d;
            tracing_q  <= tracing_d;
            done_q     <= done_d;
            rd_en_q    <= rd_en_d;
            rd_last_q  <= rd_last_d;
        end
    end

    assign tracing_out  = tracing_q;
    assign tb_we_out    = tb_we_q;
    assign tb_flag_out  = tb_flag_q;
    assign tb_waddr_out = w_wptr;
    assign rd_en_out    = rd_en_q;
    assign rd_last_out  = rd_last_q;
    assign rd_addr_out  = w_rptr;
    assign done_out     = done_q;

endmodule
`default_nettype wire

// File: doc/delta_tb_controller.md
DELTA_TB_CONTROLLER -- requirements
Module: delta_tb_controller

Interface
REQ-001 SHALL have parameter N, default 8: vector lanes (passed through for package consistency only).
REQ-002 SHALL have parameter TB_SIZE, default 64: trace buffer depth, power of two, at least 4; ADDR_W = log2(TB_SIZE).
REQ-003 SHALL have parameter DATA_WIDTH, default 32: lane width (unused in logic).
REQ-004 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have port start_in  in  1  arm request, one-cycle pulse.
REQ-007 SHALL have port trigger_in  in  1  trigger event.
REQ-008 SHALL have port post_len_in  in  ADDR_W  post-trigger entry count, sampled at start_in.
REQ-009 SHALL have port comp_valid_in, comp_flag_in, comp_inc_in  in  1 each  compressor valid_out, compression_flag_out, inc_tb_ptr.
REQ-010 SHALL have port tracing_out  out  1  drives compressor tracing.
REQ-011 SHALL have port tb_we_out, tb_flag_out  out  1 each  trace buffer write enable and per-entry flag.
REQ-012 SHALL have port tb_waddr_out  out  ADDR_W  trace buffer write address.
REQ-013 SHALL have port read_start_in, rd_ready_in  in  1 each  readout request and consumer ready.
REQ-014 SHALL have port rd_en_out, rd_last_out  out  1 each  read strobe and final-entry marker.
REQ-015 SHALL have port rd_addr_out  out  ADDR_W  read address.
REQ-016 SHALL have port done_out  out  1  capture complete, buffer frozen.

Function
REQ-017 SHALL implement FSM IDLE, ARMED, POST, DONE, READ; all outputs registered.
REQ-018 IDLE: start_in moves to ARMED and clears fill count, post count and first-write flag; trigger_in and read_start_in are ignored.
REQ-019 tracing_out SHALL be 1 exactly in ARMED and POST, changing the cycle after the state transition.
REQ-020 A write event is comp_valid_in=1 while in ARMED or POST; tb_we_out, tb_waddr_out and tb_flag_out=comp_flag_in SHALL appear one cycle after it.
REQ-021 Write address: first write after arming goes to 0 regardless of comp_inc_in; after that, comp_inc_in=1 goes to cur_addr+1 mod TB_SIZE (wrap from TB_SIZE-1 to 0) and comp_inc_in=0 overwrites cur_addr.
REQ-022 The fill count SHALL increment on every new-entry write (first write or comp_inc_in=1) and saturate at TB_SIZE.
REQ-023 ARMED: trigger_in moves to POST; a trigger on the same cycle as a write event still performs that write.
REQ-024 POST: each new-entry write increments the post count; when the count reaches post_len, move to DONE on the following cycle.
REQ-025 If post_len is 0, POST SHALL last exactly one cycle; writes in that cycle are still performed.
REQ-026 DONE: done_out=1 and writes are blocked; read_start_in moves to READ; start_in re-arms (go to ARMED, same as REQ-018).
REQ-027 READ: the first rd_addr_out is the oldest entry, i.e. (cur_addr+1) mod TB_SIZE if fill=TB_SIZE, else 0; entries are issued in order with wrap; fill entries in total.
REQ-028 rd_en_out=1 SHALL hold the address stable until a cycle with rd_ready_in=1, then advance; rd_last_out=1 with the final address.
REQ-029 The accepted final entry SHALL return the FSM to IDLE; if fill=0, READ SHALL go directly to IDLE with no rd_en_out.
REQ-030 comp_valid_in outside ARMED and POST SHALL be ignored; start_in in ARMED, POST or READ SHALL be ignored.

Reset
REQ-031 rst SHALL asynchronously force IDLE and clear every counter and the first-write flag.
REQ-032 Under rst all outputs SHALL be 0 (tracing_out, tb_we_out, tb_flag_out, tb_waddr_out, rd_en_out, rd_last_out, rd_addr_out, done_out).
REQ-033 rst mid-capture or mid-read SHALL abort with no further writes or reads; the first cycle after release is IDLE.

Structure
REQ-034 Package delta_tb_pkg SHALL hold the state enum typedef and the ADDR_W derivation function.
REQ-035 One sub-module tb_ptr_counter (modulo-TB_SIZE pointer with load and increment) SHALL be instantiated twice, for write and read.

Verification
REQ-036 TB_SIZE=8, post_len=2: start, 3 inc writes, trigger, 2 inc writes -> addrs 0..4, DONE, fill=5; read yields addrs 0,1,2,3,4, rd_last on 4.
REQ-037 Wrap: 11 inc writes, then trigger with post_len=0 -> last addr 2, fill=8; read order 3,4,5,6,7,0,1,2.
REQ-038 Overwrite: writes with comp_inc pattern 1,0,0,1 -> addrs 0,0,0,1; flags follow comp_flag_in.
REQ-039 Backpressure: rd_ready low for 3 cycles on the second entry -> rd_addr held stable; no skip, no duplicate.
REQ-040 rst asserted in POST with comp_valid high -> next cycle tb_we=0, tracing=0; after release state IDLE and trigger_in ignored.
REQ-041 Trigger simultaneous with a write in ARMED -> write performed and POST entered the same cycle; read_start with fill=0 -> IDLE, no rd_en.
